// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [31:0]             inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of imem, redirect/halt control and IF/ID handshake signals around fetch_unit.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  imem_addr;
    logic [31:0]      imem_rdata;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             halt_req;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic [XLEN-1:0]  out_pc;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output occupancy
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  occupancy
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch queue; flush wins over push/pop, and a push into a full queue
// is accepted only when the head leaves in the same cycle.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok_s, push_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == CW'(0));
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    // Next pointer and count values.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = PW'(0);
            wr_ptr_d = PW'(0);
            count_d  = CW'(0);
        end else begin
            if (push_ok_s) wr_ptr_d = wr_ptr_q + PW'(1);
            else           wr_ptr_d = wr_ptr_q;
            if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PW'(1);
            else           rd_ptr_d = rd_ptr_q;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= PW'(0);
            wr_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; stale contents are never observed because count gates the head.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, RUN/HALT state and push/redirect control around the prefetch queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = XLEN + 32;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            push_req_s, push_fire_s, pop_s;
    logic            full_s, empty_s;
    logic [CW-1:0]   count_s;
    logic [EW-1:0]   head_s;

    assign push_req_s  = (state_q == RUN) && !bus.redirect_valid && !bus.halt_req;
    assign pop_s       = !empty_s && bus.out_ready;
    assign push_fire_s = push_req_s && (!full_s || pop_s);

    // Next state and next fetch PC; a redirect overrides halt and resumes fetching.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            state_d    = RUN;
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            case (state_q)
                RUN:     state_d = bus.halt_req ? HALT : RUN;
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
            if (push_fire_s) fetch_pc_d = fetch_pc_q + XLEN'(4);
            else             fetch_pc_d = fetch_pc_q;
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_req_s),
        .pop_i   (bus.out_ready),
        .flush_i (bus.redirect_valid),
        .data_i  ({fetch_pc_q, bus.imem_rdata}),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s),
        .head_o  (head_s)
    );

    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = !empty_s;
    assign bus.out_inst  = empty_s ? NOP_INST : head_s[31:0];
    assign bus.out_pc    = empty_s ? {XLEN{1'b0}} : head_s[EW-1:32];
    assign bus.occupancy = count_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit with a queue-level reference model and scoreboard.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        int          occ;
        logic [31:0] addr;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fetch_entry_t mq[$];
    logic [31:0]  mpc = 32'h0;
    bit           mhalt = 1'b0;
    obs_t         sb_q[$];

    fetch_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

    fetch_unit #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.imem_rdata = imem_f(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc   = 32'h0;
        mhalt = 1'b0;
    endtask

    // One clock edge of the fetch rules, applied to the queue model.
    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic hr, input logic rdy);
        int sz;
        bit pop;
        sz  = mq.size();
        pop = (sz > 0) && rdy;
        if (rv) begin
            mq.delete();
            mpc   = {rpc[31:2], 2'b00};
            mhalt = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!mhalt && !hr && (sz < DEPTH || pop)) begin
                mq.push_back('{pc: mpc, inst: imem_f(mpc)});
                mpc = mpc + 32'd4;
            end
            if (hr) mhalt = 1'b1;
        end
    endtask

    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic hr,
                         input logic rdy, input logic rstn);
        obs_t o;
        @(negedge clk);
        reset              = rstn;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt_req       = hr;
        bus.out_ready      = rdy;
        if (!rstn) model_reset();
        o.valid = (mq.size() > 0);
        o.pc    = o.valid ? mq[0].pc : 32'h0;
        o.inst  = o.valid ? mq[0].inst : NOP_INST;
        o.occ   = mq.size();
        o.addr  = mpc;
        sb_q.push_back(o);
        if (rstn) model_step(rv, rpc, hr, rdy);
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, rdy, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every observable output just before each rising edge.
    initial begin
        obs_t o;
        forever begin
            @(negedge clk);
            #4;
            if (sb_q.size() > 0) begin
                o = sb_q.pop_front();
                chk("out_valid", 32'(bus.out_valid), 32'(o.valid));
                chk("occupancy", 32'(bus.occupancy), o.occ);
                chk("imem_addr", bus.imem_addr, o.addr);
                chk("out_pc", bus.out_pc, o.pc);
                chk("out_inst", bus.out_inst, o.inst);
                if (o.valid && bus.out_ready) chk("handshake_pc", bus.out_pc, o.pc);
            end
        end
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.halt_req       = 1'b0;
        bus.out_ready      = 1'b0;

        // Streaming with a ready consumer.
        do_reset();
        idle(1'b1, 8);

        // Fill to full, then drain with simultaneous push/pop.
        do_reset();
        idle(1'b0, 9);
        #2;
        chk("full_occ", 32'(bus.occupancy), 32'd4);
        chk("full_addr", bus.imem_addr, 32'd16);
        idle(1'b1, 8);

        // Redirect to a misaligned target with three entries queued.
        do_reset();
        idle(1'b0, 3);
        cycle(1'b1, 32'h103, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("redir_bubble_valid", 32'(bus.out_valid), 32'd0);
        chk("redir_bubble_occ", 32'(bus.occupancy), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("redir_first_pc", bus.out_pc, 32'h100);
        idle(1'b1, 3);

        // Halt with two entries queued, drain, then resume by redirect.
        do_reset();
        idle(1'b0, 2);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 4);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        #2;
        chk("halt_valid", 32'(bus.out_valid), 32'd0);
        chk("halt_inst", bus.out_inst, 32'h13);
        chk("halt_addr", bus.imem_addr, 32'd8);
        cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("resume_pc", bus.out_pc, 32'h40);
        idle(1'b1, 2);

        // Reset asserted mid-stream.
        idle(1'b0, 3);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_occ", 32'(bus.occupancy), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(15) == 0, $urandom, $urandom_range(31) == 0,
                  $urandom_range(3) != 0, $urandom_range(199) != 0);
        end

        @(negedge clk);
        #6;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
